// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants, FSM state encoding and the one-hot helper for the
// 16-way round-robin mux arbiter.
package mux16_rr_arbiter_pkg;

  localparam int NREQ  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Decode a select index into the matching one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    return 16'(16'h0001 << sel);
  endfunction

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Combinational round-robin picker: finds the first set bit of cand_i,
// scanning upward from last_i+1 and wrapping through 15 back to 0.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  cand_i,
  input  logic [SEL_W-1:0] last_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  logic [SEL_W-1:0]  start_s;
  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [SEL_W-1:0]  off_s;

  // 4-bit add wraps 15 -> 0 so the scan start is always in range.
  assign start_s = last_i + 4'd1;
  // Doubling the vector turns the circular scan into a plain shift.
  assign dbl_s   = {cand_i, cand_i} >> start_s;
  assign rot_s   = dbl_s[NREQ-1:0];

  // Priority-encode the rotated vector: lowest set bit wins.
  always_comb begin
    off_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        off_s = SEL_W'(i);
      end else begin
        off_s = off_s;
      end
    end
  end

  assign idx_o = start_s + off_s;
  assign any_o = |cand_i;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 bit mux.
// A grant is held while its requester keeps req high, for at most
// MAX_HOLD cycles, then rotates to the next requester.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  last_q, last_d;

  logic [NREQ-1:0]   pick_cand_s;
  logic [SEL_W-1:0]  pick_last_s;
  logic [SEL_W-1:0]  pick_idx_s;
  logic              pick_any_s;
  logic              hold_done_s;
  logic              drop_s;

  assign hold_done_s = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign drop_s      = ~req[sel_q];

  // Choose what the picker sees: full req from the saved pointer when idle;
  // while granting, search from the holder (so it ranks last) and mask it
  // out if it has dropped its request.
  always_comb begin
    pick_cand_s = req;
    pick_last_s = last_q;
    if (state_q == GRANT) begin
      pick_last_s = sel_q;
      if (drop_s) begin
        pick_cand_s = req & ~onehot(sel_q);
      end else begin
        pick_cand_s = req;
      end
    end else begin
      pick_last_s = last_q;
    end
  end

  rr_pick16 u_pick (
    .cand_i (pick_cand_s),
    .last_i (pick_last_s),
    .idx_o  (pick_idx_s),
    .any_o  (pick_any_s)
  );

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (pick_any_s) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_idx_s);
          sel_d   = pick_idx_s;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (drop_s || hold_done_s) begin
          last_d = sel_q;
          hold_d = '0;
          if (pick_any_s) begin
            state_d = GRANT;
            gnt_d   = onehot(pick_idx_s);
            sel_d   = pick_idx_s;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
        last_d  = 4'hF;
      end
    endcase
  end

  // State, pointer, hold counter and output registers with sync reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 16'h0000;
      sel_q   <= 4'h0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      last_q  <= 4'hF;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign sel_valid = valid_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        sel_valid;

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the grant, for how many cycles, and the
  // index of the most recently released holder.
  int m_holder = -1;
  int m_held   = 0;
  int m_last   = 15;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // First requester found going upward from 'from'+1 around the ring.
  function automatic int find_next(input logic [15:0] c, input int from);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      idx = (from + k) % 16;
      if (c[idx]) return idx;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the sampled rst/req.
  task automatic model_step(input logic r, input logic [15:0] q);
    logic [15:0] cand;
    int w;
    if (r) begin
      m_holder = -1;
      m_held   = 0;
      m_last   = 15;
    end else if (m_holder < 0) begin
      w = find_next(q, m_last);
      m_holder = w;
      m_held   = (w >= 0) ? 1 : 0;
    end else if (!q[m_holder] || m_held == MAX_HOLD) begin
      m_last = m_holder;
      cand   = q;
      if (!q[m_holder]) cand[m_holder] = 1'b0;
      w = find_next(cand, m_last);
      m_holder = w;
      m_held   = (w >= 0) ? 1 : 0;
    end else begin
      m_held++;
    end
  endtask

  // Apply inputs for one cycle, clock it, then compare against the model.
  task automatic cycle(input logic r, input logic [15:0] q);
    logic [15:0] e_gnt;
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    #1;
    e_gnt = (m_holder < 0) ? 16'h0000 : (16'h0001 << m_holder);
    check_eq("gnt", {16'h0000, gnt}, {16'h0000, e_gnt});
    check_eq("sel", {28'h0, sel}, (m_holder < 0) ? 32'd0 : m_holder);
    check_eq("sel_valid", {31'h0, sel_valid}, (m_holder < 0) ? 32'd0 : 32'd1);
    check_eq("onehot", {31'h0, $onehot0(gnt)}, 32'd1);
  endtask

  initial begin
    logic [15:0] rq;
    rst = 1'b1;
    req = 16'h0000;

    // Reset and idle.
    cycle(1'b1, 16'h0000);
    cycle(1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000);
    check_eq("idle_gnt", {16'h0, gnt}, 32'h0);

    // Single requester keeps its grant across hold expiries.
    cycle(1'b0, 16'h0008);
    check_eq("single_first", {16'h0, gnt}, 32'h0008);
    for (int i = 0; i < 9; i++) cycle(1'b0, 16'h0008);
    check_eq("single_last_sel", {28'h0, sel}, 32'd3);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);

    // Full contention from a fresh reset: 0,1,...,15 each for 4 cycles.
    cycle(1'b1, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 16'hFFFF);
      check_eq("rr_seq", {28'h0, sel}, i / 4);
    end
    cycle(1'b0, 16'hFFFF);
    check_eq("rr_wrap", {28'h0, sel}, 32'd0);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);

    // Early drop hands straight over with no bubble, then goes idle.
    cycle(1'b1, 16'h0000);
    cycle(1'b0, 16'h0011);
    cycle(1'b0, 16'h0011);
    cycle(1'b0, 16'h0010);
    check_eq("drop_handoff_gnt", {16'h0, gnt}, 32'h0010);
    check_eq("drop_handoff_sel", {28'h0, sel}, 32'd4);
    cycle(1'b0, 16'h0010);
    cycle(1'b0, 16'h0000);
    check_eq("drop_idle_gnt", {16'h0, gnt}, 32'h0000);

    // Pointer fairness: 5 served, then 0, then 5 again.
    cycle(1'b0, 16'h0020);
    check_eq("fair_first", {28'h0, sel}, 32'd5);
    cycle(1'b0, 16'h0021);
    cycle(1'b0, 16'h0021);
    cycle(1'b0, 16'h0021);
    cycle(1'b0, 16'h0021);
    check_eq("fair_second", {28'h0, sel}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0021);
    check_eq("fair_third", {28'h0, sel}, 32'd5);
    cycle(1'b0, 16'h0000);

    // Reset in the middle of a grant.
    cycle(1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0F00);
    check_eq("pre_rst_sel", {28'h0, sel}, 32'd9);
    cycle(1'b1, 16'h0F00);
    check_eq("mid_rst_gnt", {16'h0, gnt}, 32'h0);
    check_eq("mid_rst_valid", {31'h0, sel_valid}, 32'd0);
    cycle(1'b0, 16'h0F00);
    check_eq("post_rst_sel", {28'h0, sel}, 32'd8);

    // Random traffic, requests often held to exercise hold expiry.
    rq = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: rq = 16'h0001 << $urandom_range(0, 15);
          1: rq = 16'($urandom);
          2: rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
          default: rq = 16'h0000;
        endcase
      end
      cycle(($urandom_range(0, 99) == 0), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares one 16:1 bit multiplexer among 16 requesters.
- Drives the mux 4-bit select (sel) and a one-hot grant vector.
- Each grant is held while the requester keeps req asserted, up to MAX_HOLD cycles, then rotates.
- Sits directly in front of the 16:1 mux. The mux output f is consumed by whichever requester holds gnt.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold the grant (legal range 1..16).
- HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i is requester i, level-sensitive.
- gnt  output  16  one-hot grant, registered; all zero when idle.
- sel  output  4  mux select = index of the granted requester, registered.
- sel_valid  output  1  high while any grant is active (equals |gnt).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - gnt = 16'h0000, sel = 4'h0, sel_valid = 0.
  - state = IDLE, hold_cnt = 0.
  - last = 4'hF, so requester 0 has top priority after reset.
- Pick function:
  - Scan starts at (last+1) mod 16 and wraps upward through 15 to 0.
  - The first set bit of the candidate vector wins.
  - The index arithmetic is 4-bit and wraps naturally.
- State IDLE:
  - If req != 0, the next edge enters GRANT with gnt/sel set to pick(req).
  - Latency: req sampled in cycle N gives gnt valid in cycle N+1.
  - If req == 0, stay in IDLE with outputs at zero.
- State GRANT:
  - hold_cnt increments every cycle.
  - Release occurs when req[sel] == 0, or when hold_cnt == MAX_HOLD-1 (grant held for MAX_HOLD cycles).
  - On release, last <= sel and hold_cnt <= 0.
- Release caused by req drop:
  - The candidate vector is req with bit sel masked.
  - If the candidate is nonzero, re-grant on the next edge with no idle bubble (back-to-back).
  - Otherwise go to IDLE and clear gnt, sel, and sel_valid (sel returns to 0).
- Release caused by hold expiry:
  - The candidate vector is the full req, searched from last+1.
  - The current holder is therefore lowest priority.
  - If it is the only requester, it is re-granted with hold_cnt restarting at 0. gnt stays high continuously.
- No preemption: a new higher-priority request never interrupts an active grant before release.
- A requester that drops req mid-grant loses the grant on the next edge. gnt falls one cycle after req falls.
- req changing on the same edge as release: the arbiter uses the req value sampled at that edge.
- Reset asserted mid-grant: all outputs return to reset values on that edge. Pointer last returns to 4'hF.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt == (sel_valid ? 1 << sel : 0).

Decomposition:
- Shared package holds:
  - constants NREQ = 16 and SEL_W = 4;
  - state encoding enum IDLE = 1'b0, GRANT = 1'b1;
  - function onehot(sel).
- One combinational sub-module, rr_pick16:
  - inputs: 16-bit candidate vector and 4-bit last;
  - outputs: 4-bit winner index and any-set flag;
  - implementation: double-width rotate and priority encode.
- The top level holds the FSM, hold counter, pointer, and output registers.

Test Plan:
- Reset, then req = 16'h0000 for 5 cycles -> gnt = 0, sel = 0, sel_valid = 0 throughout.
- Single requester: req = 16'h0008 held for 10 cycles -> gnt = 16'h0008 and sel = 3 from cycle 1 on. gnt stays continuously high across hold expiries (MAX_HOLD = 4).
- Full contention: req = 16'hFFFF for 64 cycles -> sel sequence 0,1,2,…,15 with each value lasting exactly 4 cycles. Wraps 15 -> 0 with no idle cycle.
- Early drop: req = 16'h0011, then req[0] drops 2 cycles into its grant -> the next cycle gives gnt = 16'h0010 and sel = 4 (no bubble). When req[4] drops, the next cycle gives gnt = 0.
- Pointer fairness: after requester 5 completes, req = 16'h0021 -> requester 0 wait time is bounded, and the grant goes to 5 only after 0 has been served. Check sel order 5, 0, 5.
- Mid-grant reset: req = 16'h0F00 with rst pulsed during the grant to 9 -> outputs zero on that edge. After rst falls, the first grant is sel = 8 (pointer reset to 4'hF).
